// File: rtl/stream_pkt_arbiter_pkg.sv
// Shared types and helpers for the packet-aware weighted round-robin arbiter.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package stream_pkt_arbiter_pkg;

  // IDLE: free to pick a new source; LOCKED: grant pinned to owner until last beat.
  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

  // Widest weight field the helper handles; narrower fields are zero-extended.
  localparam int unsigned MaxWeightWidth = 16;

  // A programmed weight of zero still grants one packet per turn.
  function automatic logic [MaxWeightWidth-1:0] eff_weight(input logic [MaxWeightWidth-1:0] w);
    return (w == '0) ? MaxWeightWidth'(1) : w;
  endfunction

endpackage

// File: rtl/stream_pkt_arbiter_sel.sv
// Cyclic priority selector: first valid index at or above rr, else wraps to the lowest valid.
// Latency: purely combinational.
// Backpressure: none; it only ranks requests.
module stream_pkt_arbiter_sel #(
  parameter int unsigned NumIn    = 4,
  parameter int unsigned IdxWidth = $clog2(NumIn)
) (
  input  logic [NumIn-1:0]    valid,
  input  logic [IdxWidth-1:0] rr,
  output logic [IdxWidth-1:0] sel_idx,
  output logic                empty
);

  logic [NumIn-1:0]    upper;
  logic [NumIn-1:0]    lower;
  logic [IdxWidth-1:0] upper_idx;
  logic [IdxWidth-1:0] lower_idx;

  // Lowest set bit of a request vector (zero when none are set).
  function automatic logic [IdxWidth-1:0] first_set(input logic [NumIn-1:0] v);
    logic [IdxWidth-1:0] idx;
    idx = '0;
    for (int i = NumIn - 1; i >= 0; i--) begin
      if (v[i]) idx = IdxWidth'(i);
    end
    return idx;
  endfunction

  // Split requests into the part at/after the rr pointer and the wrapped-around part.
  always_comb begin
    upper = '0;
    lower = '0;
    for (int i = 0; i < NumIn; i++) begin
      if (i >= int'(rr)) upper[i] = valid[i];
      else               lower[i] = valid[i];
    end
  end

  // Upper half wins; the wrapped half is only consulted when nothing sits at/after rr.
  always_comb begin
    upper_idx = first_set(upper);
    lower_idx = first_set(lower);
    sel_idx   = (|upper) ? upper_idx : lower_idx;
    empty     = ~|valid;
  end

endmodule

// File: rtl/stream_pkt_arbiter.sv
// Packet-aware weighted round-robin arbiter: many valid/ready sources onto one sink, packets kept whole.
// Latency: zero-cycle combinational forwarding; no register in the data path.
// Backpressure: sink ready is routed to the single selected source; the choice freezes while stalled.
module stream_pkt_arbiter
  import stream_pkt_arbiter_pkg::*;
#(
  parameter int unsigned NumIn       = 4,
  parameter int unsigned DataWidth   = 32,
  parameter int unsigned WeightWidth = 4,
  parameter int unsigned IdxWidth    = $clog2(NumIn)
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         flush_i,
  input  logic [NumIn*WeightWidth-1:0] weight_i,
  input  logic [NumIn-1:0]             valid_i,
  output logic [NumIn-1:0]             ready_o,
  input  logic [NumIn-1:0]             last_i,
  input  logic [NumIn*DataWidth-1:0]   data_i,
  output logic                         valid_o,
  input  logic                         ready_i,
  output logic                         last_o,
  output logic [DataWidth-1:0]         data_o,
  output logic [IdxWidth-1:0]          idx_o,
  output logic                         busy_o
);

  state_e                state_q;
  logic [IdxWidth-1:0]   owner_q;
  logic [IdxWidth-1:0]   rr_q;
  logic [WeightWidth-1:0] credit_q;

  logic [IdxWidth-1:0]   sel_idx;
  logic                  sel_empty;
  logic [IdxWidth-1:0]   cur_idx;
  logic                  pkt_done;
  logic                  keep_turn;
  logic [IdxWidth-1:0]   rr_adv;
  logic [MaxWeightWidth-1:0] w_eff;
  logic [MaxWeightWidth-1:0] credit_inc;

  logic [DataWidth-1:0]   data_arr   [NumIn];
  logic [WeightWidth-1:0] weight_arr [NumIn];

  for (genvar g = 0; g < NumIn; g++) begin : g_unpack
    assign data_arr[g]   = data_i[g*DataWidth +: DataWidth];
    assign weight_arr[g] = weight_i[g*WeightWidth +: WeightWidth];
  end

  stream_pkt_arbiter_sel #(
    .NumIn   (NumIn),
    .IdxWidth(IdxWidth)
  ) u_sel (
    .valid  (valid_i),
    .rr     (rr_q),
    .sel_idx(sel_idx),
    .empty  (sel_empty)
  );

  // Route the chosen source (owner when locked, fresh pick when idle) to the sink.
  always_comb begin
    cur_idx = (state_q == LOCKED) ? owner_q : sel_idx;
    valid_o = (state_q == LOCKED) ? valid_i[owner_q] : ~sel_empty;
    data_o  = data_arr[cur_idx];
    last_o  = last_i[cur_idx];
    idx_o   = cur_idx;
    ready_o = '0;
    ready_o[cur_idx] = valid_o & ready_i;
  end

  // Work out the weighted-turn bookkeeping for a packet that finishes this cycle.
  always_comb begin
    pkt_done   = valid_o & ready_i & last_o;
    w_eff      = eff_weight(MaxWeightWidth'(weight_arr[cur_idx]));
    credit_inc = MaxWeightWidth'(credit_q) + MaxWeightWidth'(1);
    keep_turn  = (credit_inc < w_eff);
    rr_adv     = (cur_idx == IdxWidth'(NumIn - 1)) ? '0 : cur_idx + 1'b1;
  end

  // Packet FSM plus rr/credit registers; flush beats every other update.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= '0;
    end else if (flush_i) begin
      state_q  <= IDLE;
      owner_q  <= '0;
      rr_q     <= '0;
      credit_q <= '0;
    end else if (pkt_done) begin
      state_q <= IDLE;
      if (keep_turn) begin
        credit_q <= credit_q + 1'b1;
        rr_q     <= cur_idx;
      end else begin
        credit_q <= '0;
        rr_q     <= rr_adv;
      end
    end else if (state_q == IDLE && valid_o) begin
      // Either a multi-beat packet started or the sink stalled: pin the choice.
      state_q <= LOCKED;
      owner_q <= cur_idx;
    end
  end

  assign busy_o = (state_q == LOCKED);

endmodule
